// File: rtl/bju_resolve_if.sv
// rtl/bju_resolve_if.sv - channel, redirect and BPU-update signal bundle for bju_resolve
interface bju_resolve_if #(
    parameter int NR_CH = 2,
    parameter int ROB_W = 5
);
    logic                     flush_i;
    logic [ROB_W-1:0]         rob_head_i;
    logic [NR_CH-1:0]         ch_valid_i;
    logic [2*NR_CH-1:0]       ch_op_i;
    logic [NR_CH-1:0]         ch_rv16_i;
    logic [NR_CH-1:0]         ch_cmp_i;
    logic [32*NR_CH-1:0]      ch_pc_i;
    logic [32*NR_CH-1:0]      ch_opa_i;
    logic [32*NR_CH-1:0]      ch_imm_i;
    logic [32*NR_CH-1:0]      ch_pred_addr_i;
    logic [3*NR_CH-1:0]       ch_pred_cf_i;
    logic [ROB_W*NR_CH-1:0]   ch_rob_i;

    logic [NR_CH-1:0]         res_valid_o;
    logic [32*NR_CH-1:0]      res_link_o;
    logic [ROB_W*NR_CH-1:0]   res_rob_o;

    logic                     redirect_valid_o;
    logic [31:0]              redirect_pc_o;
    logic [ROB_W-1:0]         redirect_rob_o;

    logic                     upd_valid_o;
    logic                     upd_ready_i;
    logic [31:0]              upd_pc_o;
    logic [31:0]              upd_target_o;
    logic                     upd_taken_o;
    logic [2:0]               upd_cf_o;
    logic [7:0]               drop_cnt_o;

    modport master (
        output flush_i, rob_head_i, ch_valid_i, ch_op_i, ch_rv16_i, ch_cmp_i,
               ch_pc_i, ch_opa_i, ch_imm_i, ch_pred_addr_i, ch_pred_cf_i, ch_rob_i,
               upd_ready_i,
        input  res_valid_o, res_link_o, res_rob_o,
               redirect_valid_o, redirect_pc_o, redirect_rob_o,
               upd_valid_o, upd_pc_o, upd_target_o, upd_taken_o, upd_cf_o, drop_cnt_o
    );

    modport slave (
        input  flush_i, rob_head_i, ch_valid_i, ch_op_i, ch_rv16_i, ch_cmp_i,
               ch_pc_i, ch_opa_i, ch_imm_i, ch_pred_addr_i, ch_pred_cf_i, ch_rob_i,
               upd_ready_i,
        output res_valid_o, res_link_o, res_rob_o,
               redirect_valid_o, redirect_pc_o, redirect_rob_o,
               upd_valid_o, upd_pc_o, upd_target_o, upd_taken_o, upd_cf_o, drop_cnt_o
    );
endinterface

// File: rtl/bju_resolve.sv
// rtl/bju_resolve.sv - branch/jump resolution with oldest-mispredict redirect and BPU-update FIFO
// cf_t encoding: 0 none, 1 branch, 2 jal, 3 jalr, 4 ret; op: 00 branch, 01 jal, 10 jalr.
module bju_resolve #(
    parameter int NR_CH     = 2,
    parameter int ROB_W     = 5,
    parameter int UPD_DEPTH = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    bju_resolve_if.slave bus
);
    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_JALR   = 2'b10;
    localparam logic [2:0] CF_NONE   = 3'd0;
    localparam logic [2:0] CF_BRANCH = 3'd1;
    localparam logic [2:0] CF_JALR   = 3'd3;
    localparam logic [2:0] CF_RET    = 3'd4;
    localparam int AW = $clog2(UPD_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {S_IDLE, S_PENDING} state_t;

    logic [1:0]          op      [NR_CH];
    logic [2:0]          pcf     [NR_CH];
    logic [31:0]         pc      [NR_CH];
    logic [31:0]         tgt     [NR_CH];
    logic [31:0]         lnk     [NR_CH];
    logic [31:0]         fix_pc  [NR_CH];
    logic [ROB_W-1:0]    rob     [NR_CH];
    logic [ROB_W-1:0]    age     [NR_CH];
    logic [2:0]          ucf     [NR_CH];
    logic [NR_CH-1:0]    mis;
    logic [NR_CH-1:0]    upd_req;
    logic [NR_CH-1:0]    utaken;
    logic [NR_CH-1:0]    live;
    logic [NR_CH-1:0]    push;
    logic [32*NR_CH-1:0] link_flat;

    always_comb begin
        link_flat = '0;
        for (int i = 0; i < NR_CH; i++) begin
            op[i]     = bus.ch_op_i[2*i +: 2];
            pcf[i]    = bus.ch_pred_cf_i[3*i +: 3];
            pc[i]     = bus.ch_pc_i[32*i +: 32];
            rob[i]    = bus.ch_rob_i[ROB_W*i +: ROB_W];
            age[i]    = rob[i] - bus.rob_head_i;
            lnk[i]    = pc[i] + (bus.ch_rv16_i[i] ? 32'd2 : 32'd4);
            tgt[i]    = ((op[i] == OP_JALR) ? bus.ch_opa_i[32*i +: 32] : pc[i])
                        + bus.ch_imm_i[32*i +: 32];
            if (op[i] == OP_JALR) begin
                tgt[i][0] = 1'b0;
            end
            mis[i]     = 1'b0;
            upd_req[i] = 1'b0;
            utaken[i]  = 1'b1;
            ucf[i]     = CF_BRANCH;
            fix_pc[i]  = tgt[i];
            case (op[i])
                OP_BRANCH: begin
                    mis[i]     = bus.ch_cmp_i[i] != (pcf[i] == CF_BRANCH);
                    upd_req[i] = 1'b1;
                    utaken[i]  = bus.ch_cmp_i[i];
                    fix_pc[i]  = bus.ch_cmp_i[i] ? tgt[i] : lnk[i];
                end
                OP_JALR: begin
                    mis[i]     = (pcf[i] == CF_NONE) || (tgt[i] != bus.ch_pred_addr_i[32*i +: 32]);
                    upd_req[i] = mis[i];
                    ucf[i]     = (pcf[i] == CF_RET) ? CF_RET : CF_JALR;
                end
                default: ;
            endcase
            link_flat[32*i +: 32] = lnk[i];
        end
    end

    state_t           state;
    logic [ROB_W-1:0] pending_rob;
    logic [ROB_W-1:0] pend_age;
    logic [ROB_W-1:0] sel_age;
    logic [ROB_W-1:0] sel_rob;
    logic [31:0]      sel_pc;
    logic             sel_found;

    // Oldest mispredict that is itself older than any pending one wins; everything
    // younger than the resulting boundary is squashed.
    always_comb begin
        pend_age  = pending_rob - bus.rob_head_i;
        sel_found = 1'b0;
        sel_age   = '1;
        sel_rob   = '0;
        sel_pc    = '0;
        for (int i = 0; i < NR_CH; i++) begin
            if (bus.ch_valid_i[i] && !bus.flush_i && mis[i]
                && (state == S_IDLE || age[i] < pend_age)
                && (!sel_found || age[i] < sel_age)) begin
                sel_found = 1'b1;
                sel_age   = age[i];
                sel_rob   = rob[i];
                sel_pc    = fix_pc[i];
            end
        end
        for (int i = 0; i < NR_CH; i++) begin
            live[i] = bus.ch_valid_i[i] && !bus.flush_i
                      && !(sel_found && age[i] > sel_age)
                      && !(state == S_PENDING && age[i] > pend_age);
            push[i] = live[i] && upd_req[i];
        end
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] used;
    logic [PW-1:0] free_slots;
    logic [PW-1:0] n_acc;
    logic [3:0]    n_drop;
    logic [8:0]    drop_sum;
    logic [7:0]    drop_cnt;
    logic [AW-1:0] wr_addr [NR_CH];
    logic [NR_CH-1:0] wr_en;
    logic          fifo_nempty;
    logic          pop;
    logic [AW-1:0] rd_addr;

    logic [31:0]   mem_pc    [UPD_DEPTH];
    logic [31:0]   mem_tgt   [UPD_DEPTH];
    logic          mem_taken [UPD_DEPTH];
    logic [2:0]    mem_cf    [UPD_DEPTH];

    // Free space is taken before this cycle's pop, so a full FIFO drops even while draining.
    always_comb begin
        used       = wr_ptr - rd_ptr;
        free_slots = PW'(UPD_DEPTH) - used;
        n_acc      = '0;
        n_drop     = '0;
        for (int i = 0; i < NR_CH; i++) begin
            wr_en[i]   = 1'b0;
            wr_addr[i] = '0;
            if (push[i]) begin
                if (n_acc < free_slots) begin
                    wr_en[i]   = 1'b1;
                    wr_addr[i] = AW'(wr_ptr + n_acc);
                    n_acc      = n_acc + PW'(1);
                end else begin
                    n_drop = n_drop + 4'd1;
                end
            end
        end
        drop_sum = {1'b0, drop_cnt} + {5'b0, n_drop};
    end

    assign fifo_nempty = (used != '0);
    assign pop         = fifo_nempty && bus.upd_ready_i;
    assign rd_addr     = rd_ptr[AW-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
        end else begin
            wr_ptr   <= wr_ptr + n_acc;
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_CH; i++) begin
            if (wr_en[i]) begin
                mem_pc[wr_addr[i]]    <= pc[i];
                mem_tgt[wr_addr[i]]   <= tgt[i];
                mem_taken[wr_addr[i]] <= utaken[i];
                mem_cf[wr_addr[i]]    <= ucf[i];
            end
        end
    end

    logic [NR_CH-1:0]       res_valid_q;
    logic [32*NR_CH-1:0]    res_link_q;
    logic [ROB_W*NR_CH-1:0] res_rob_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_valid_q <= '0;
            res_link_q  <= '0;
            res_rob_q   <= '0;
        end else begin
            res_valid_q <= live;
            res_link_q  <= link_flat;
            res_rob_q   <= bus.ch_rob_i;
        end
    end

    logic             redir_valid;
    logic [31:0]      redir_pc;
    logic [ROB_W-1:0] redir_rob;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            pending_rob <= '0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            redir_rob   <= '0;
        end else begin
            redir_valid <= 1'b0;
            if (bus.flush_i) begin
                state       <= S_IDLE;
                pending_rob <= '0;
            end else begin
                case (state)
                    S_IDLE, S_PENDING: begin
                        if (sel_found) begin
                            state       <= S_PENDING;
                            pending_rob <= sel_rob;
                            redir_valid <= 1'b1;
                            redir_pc    <= sel_pc;
                            redir_rob   <= sel_rob;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.res_valid_o      = res_valid_q;
    assign bus.res_link_o       = res_link_q;
    assign bus.res_rob_o        = res_rob_q;
    assign bus.redirect_valid_o = redir_valid;
    assign bus.redirect_pc_o    = redir_pc;
    assign bus.redirect_rob_o   = redir_rob;
    assign bus.upd_valid_o      = fifo_nempty;
    assign bus.upd_pc_o         = fifo_nempty ? mem_pc[rd_addr]    : 32'd0;
    assign bus.upd_target_o     = fifo_nempty ? mem_tgt[rd_addr]   : 32'd0;
    assign bus.upd_taken_o      = fifo_nempty ? mem_taken[rd_addr] : 1'b0;
    assign bus.upd_cf_o         = fifo_nempty ? mem_cf[rd_addr]    : 3'd0;
    assign bus.drop_cnt_o       = drop_cnt;
endmodule

// File: tb/tb_bju_resolve.sv
// tb/tb_bju_resolve.sv - directed and randomized checks of bju_resolve against a behavioural model
module tb_bju_resolve;
    localparam int NR_CH     = 2;
    localparam int ROB_W     = 5;
    localparam int UPD_DEPTH = 8;
    localparam int ROB_N     = 1 << ROB_W;
    localparam logic [2:0] CF_NONE   = 3'd0;
    localparam logic [2:0] CF_BRANCH = 3'd1;
    localparam logic [2:0] CF_JALR   = 3'd3;
    localparam logic [2:0] CF_RET    = 3'd4;
    localparam logic [1:0] OP_BR     = 2'b00;
    localparam logic [1:0] OP_JALR   = 2'b10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bju_resolve_if #(.NR_CH(NR_CH), .ROB_W(ROB_W)) bus ();
    bju_resolve #(.NR_CH(NR_CH), .ROB_W(ROB_W), .UPD_DEPTH(UPD_DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic [2:0]  cf;
    } upd_t;

    upd_t        mq[$];
    int          errors = 0;
    int          checks = 0;
    bit          m_pend;
    int          m_prob;
    int          m_drop;
    bit          e_rv   [NR_CH];
    logic [31:0] e_link [NR_CH];
    int          e_rob  [NR_CH];
    bit          e_redir;
    logic [31:0] e_rpc;
    int          e_rrob;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.flush_i        = 1'b0;
        bus.rob_head_i     = '0;
        bus.ch_valid_i     = '0;
        bus.ch_op_i        = '0;
        bus.ch_rv16_i      = '0;
        bus.ch_cmp_i       = '0;
        bus.ch_pc_i        = '0;
        bus.ch_opa_i       = '0;
        bus.ch_imm_i       = '0;
        bus.ch_pred_addr_i = '0;
        bus.ch_pred_cf_i   = '0;
        bus.ch_rob_i       = '0;
        bus.upd_ready_i    = 1'b0;
    endtask

    task automatic set_ch(input int c, input bit v, input logic [1:0] op,
                          input logic [31:0] pc, input logic [31:0] opa, input logic [31:0] imm,
                          input bit rv16, input bit cmp, input logic [2:0] pcf,
                          input logic [31:0] paddr, input int rob);
        bus.ch_valid_i[c]              = v;
        bus.ch_op_i[2*c +: 2]          = op;
        bus.ch_pc_i[32*c +: 32]        = pc;
        bus.ch_opa_i[32*c +: 32]       = opa;
        bus.ch_imm_i[32*c +: 32]       = imm;
        bus.ch_rv16_i[c]               = rv16;
        bus.ch_cmp_i[c]                = cmp;
        bus.ch_pred_cf_i[3*c +: 3]     = pcf;
        bus.ch_pred_addr_i[32*c +: 32] = paddr;
        bus.ch_rob_i[ROB_W*c +: ROB_W] = ROB_W'(rob);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend  = 1'b0;
        m_prob  = 0;
        m_drop  = 0;
        e_redir = 1'b0;
        for (int c = 0; c < NR_CH; c++) e_rv[c] = 1'b0;
    endtask

    // Expected outputs after the coming edge, from the driven inputs and the model state.
    task automatic model_cycle();
        int          head, pend_age, limit, best, n_free;
        int          age  [NR_CH];
        bit          mis  [NR_CH];
        bit          want [NR_CH];
        logic [31:0] fpc  [NR_CH];
        upd_t        u    [NR_CH];
        upd_t        pushes[$];
        bit          do_pop;
        logic [1:0]  op;
        logic [2:0]  pcf;
        logic [31:0] pc, tgt, lnk;
        bit          cmp;
        head    = int'(bus.rob_head_i);
        do_pop  = bus.upd_ready_i && (mq.size() > 0);
        e_redir = 1'b0;
        for (int c = 0; c < NR_CH; c++) begin
            e_rv[c] = 1'b0; mis[c] = 1'b0; want[c] = 1'b0; age[c] = 0; fpc[c] = '0;
            u[c].pc = '0; u[c].target = '0; u[c].taken = 1'b0; u[c].cf = '0;
        end
        if (bus.flush_i) begin
            m_pend = 1'b0;
        end else begin
            for (int c = 0; c < NR_CH; c++) begin
                if (bus.ch_valid_i[c]) begin
                    op  = bus.ch_op_i[2*c +: 2];
                    pcf = bus.ch_pred_cf_i[3*c +: 3];
                    pc  = bus.ch_pc_i[32*c +: 32];
                    cmp = bus.ch_cmp_i[c];
                    lnk = pc + (bus.ch_rv16_i[c] ? 32'd2 : 32'd4);
                    if (op == OP_JALR) tgt = (bus.ch_opa_i[32*c +: 32] + bus.ch_imm_i[32*c +: 32]) & 32'hFFFF_FFFE;
                    else               tgt = pc + bus.ch_imm_i[32*c +: 32];
                    e_rob[c]  = int'(bus.ch_rob_i[ROB_W*c +: ROB_W]);
                    e_link[c] = lnk;
                    age[c]    = (e_rob[c] - head + ROB_N) % ROB_N;
                    u[c].pc = pc; u[c].target = tgt;
                    if (op == OP_BR) begin
                        mis[c] = (cmp != (pcf == CF_BRANCH));
                        want[c] = 1'b1; u[c].taken = cmp; u[c].cf = CF_BRANCH;
                        fpc[c] = cmp ? tgt : lnk;
                    end else if (op == OP_JALR) begin
                        mis[c] = (pcf == CF_NONE) || (tgt != bus.ch_pred_addr_i[32*c +: 32]);
                        want[c] = mis[c]; u[c].taken = 1'b1;
                        u[c].cf = (pcf == CF_RET) ? CF_RET : CF_JALR;
                        fpc[c] = tgt;
                    end
                end
            end
            pend_age = m_pend ? (m_prob - head + ROB_N) % ROB_N : ROB_N;
            best = -1;
            for (int c = 0; c < NR_CH; c++)
                if (bus.ch_valid_i[c] && mis[c] && age[c] < pend_age && (best < 0 || age[c] < age[best]))
                    best = c;
            limit = pend_age;
            if (best >= 0) begin
                limit   = age[best];
                e_redir = 1'b1;
                e_rpc   = fpc[best];
                e_rrob  = e_rob[best];
                m_pend  = 1'b1;
                m_prob  = e_rob[best];
            end
            for (int c = 0; c < NR_CH; c++) begin
                if (bus.ch_valid_i[c] && age[c] <= limit) begin
                    e_rv[c] = 1'b1;
                    if (want[c]) pushes.push_back(u[c]);
                end
            end
        end
        n_free = UPD_DEPTH - mq.size();
        foreach (pushes[k]) begin
            if (n_free > 0) begin
                mq.push_back(pushes[k]);
                n_free--;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        if (do_pop) void'(mq.pop_front());
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < NR_CH; c++) begin
            chk($sformatf("%s/res_valid%0d", tag, c), 32'(bus.res_valid_o[c]), 32'(e_rv[c]));
            if (e_rv[c]) begin
                chk($sformatf("%s/res_link%0d", tag, c), bus.res_link_o[32*c +: 32], e_link[c]);
                chk($sformatf("%s/res_rob%0d", tag, c), 32'(bus.res_rob_o[ROB_W*c +: ROB_W]), 32'(e_rob[c]));
            end
        end
        chk({tag, "/redir_valid"}, 32'(bus.redirect_valid_o), 32'(e_redir));
        if (e_redir) begin
            chk({tag, "/redir_pc"}, bus.redirect_pc_o, e_rpc);
            chk({tag, "/redir_rob"}, 32'(bus.redirect_rob_o), 32'(e_rrob));
        end
        chk({tag, "/upd_valid"}, 32'(bus.upd_valid_o), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk({tag, "/upd_pc"}, bus.upd_pc_o, mq[0].pc);
            chk({tag, "/upd_target"}, bus.upd_target_o, mq[0].target);
            chk({tag, "/upd_taken"}, 32'(bus.upd_taken_o), 32'(mq[0].taken));
            chk({tag, "/upd_cf"}, 32'(bus.upd_cf_o), 32'(mq[0].cf));
        end
        chk({tag, "/drop_cnt"}, 32'(bus.drop_cnt_o), 32'(m_drop));
    endtask

    task automatic cycle(input string tag);
        model_cycle();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [2:0]  r_pcf;
        logic [31:0] r_pc, r_opa, r_imm, r_tgt, r_pa;
        int          robs [NR_CH];
        int          r;
        bit          ok;

        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset/res_valid", 32'(bus.res_valid_o), 32'd0);
        chk("reset/res_link", bus.res_link_o[31:0], 32'd0);
        chk("reset/redir_valid", 32'(bus.redirect_valid_o), 32'd0);
        chk("reset/redir_pc", bus.redirect_pc_o, 32'd0);
        chk("reset/upd_valid", 32'(bus.upd_valid_o), 32'd0);
        chk("reset/upd_pc", bus.upd_pc_o, 32'd0);
        chk("reset/drop_cnt", 32'(bus.drop_cnt_o), 32'd0);
        rst = 1'b0;

        // JALR with no prediction
        set_ch(0, 1, OP_JALR, 32'h100, 32'h2001, 32'd4, 0, 0, CF_NONE, 32'h0, 0);
        cycle("jalr_none");
        chk("jalr/redir_valid", 32'(bus.redirect_valid_o), 32'd1);
        chk("jalr/redir_pc", bus.redirect_pc_o, 32'h2004);
        chk("jalr/upd_cf", 32'(bus.upd_cf_o), 32'(CF_JALR));
        chk("jalr/link", bus.res_link_o[31:0], 32'h104);
        clear_inputs(); bus.flush_i = 1'b1;
        cycle("flush1");
        clear_inputs(); bus.upd_ready_i = 1'b1;
        cycle("drain1");

        // two same-cycle branch mispredicts: older channel 1 wins
        clear_inputs();
        set_ch(0, 1, OP_BR, 32'h400, 32'h0, 32'h40, 0, 1, CF_NONE,   32'h0, 5);
        set_ch(1, 1, OP_BR, 32'h500, 32'h0, 32'h8,  0, 0, CF_BRANCH, 32'h0, 3);
        cycle("two_mis");
        chk("two_mis/redir_rob", 32'(bus.redirect_rob_o), 32'd3);
        chk("two_mis/redir_pc", bus.redirect_pc_o, 32'h504);
        chk("two_mis/res_valid", 32'(bus.res_valid_o), 32'b10);
        clear_inputs(); bus.flush_i = 1'b1;
        cycle("flush2");
        clear_inputs(); bus.upd_ready_i = 1'b1;
        repeat (2) cycle("drain2");

        // age wrap around the ROB head
        clear_inputs(); bus.rob_head_i = 5'd30;
        set_ch(0, 1, OP_BR, 32'h600, 32'h0, 32'h20, 1, 1, CF_NONE, 32'h0, 31);
        cycle("wrap_pend");
        chk("wrap_pend/redir_rob", 32'(bus.redirect_rob_o), 32'd31);
        set_ch(0, 1, OP_BR, 32'h700, 32'h0, 32'h20, 0, 1, CF_NONE, 32'h0, 1);
        cycle("wrap_squash");
        chk("wrap_squash/redir_valid", 32'(bus.redirect_valid_o), 32'd0);
        chk("wrap_squash/res_valid", 32'(bus.res_valid_o), 32'd0);
        set_ch(0, 1, OP_JALR, 32'h800, 32'h3000, 32'h10, 0, 0, CF_RET, 32'h0, 30);
        cycle("wrap_older");
        chk("wrap_older/redir_rob", 32'(bus.redirect_rob_o), 32'd30);
        clear_inputs(); bus.flush_i = 1'b1;
        cycle("flush3");
        clear_inputs(); bus.upd_ready_i = 1'b1;
        repeat (UPD_DEPTH) cycle("drain3");

        // FIFO overflow: 7 entries then two pushes
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            set_ch(0, 1, OP_BR, 32'h1000 + 32'(16*k), 32'h0, 32'h80, 0, 0, CF_NONE, 32'h0, 2*k);
            set_ch(1, (k < 3), OP_BR, 32'h2000 + 32'(16*k), 32'h0, 32'h80, 0, 0, CF_NONE, 32'h0, 2*k+1);
            cycle("fill");
        end
        set_ch(0, 1, OP_BR, 32'h3000, 32'h0, 32'h4, 0, 0, CF_NONE, 32'h0, 10);
        set_ch(1, 1, OP_BR, 32'h3100, 32'h0, 32'h4, 0, 0, CF_NONE, 32'h0, 11);
        cycle("overflow");
        chk("overflow/drop_cnt", 32'(bus.drop_cnt_o), 32'd1);
        chk("overflow/res_valid", 32'(bus.res_valid_o), 32'b11);

        // asynchronous reset while pending with entries queued
        clear_inputs(); bus.upd_ready_i = 1'b1;
        repeat (6) cycle("pop6");
        clear_inputs();
        set_ch(0, 1, OP_BR, 32'h4000, 32'h0, 32'h40, 0, 1, CF_NONE, 32'h0, 2);
        cycle("pend_entry");
        chk("pend_entry/redir_valid", 32'(bus.redirect_valid_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst/upd_valid", 32'(bus.upd_valid_o), 32'd0);
        chk("async_rst/redir_valid", 32'(bus.redirect_valid_o), 32'd0);
        chk("async_rst/drop_cnt", 32'(bus.drop_cnt_o), 32'd0);
        model_reset();
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_ch(0, 1, OP_BR, 32'h5000, 32'h0, 32'h40, 0, 1, CF_NONE, 32'h0, 9);
        cycle("after_rst");
        chk("after_rst/redir_rob", 32'(bus.redirect_rob_o), 32'd9);

        // randomized traffic
        for (int n = 0; n < 700; n++) begin
            clear_inputs();
            bus.flush_i     = ($urandom_range(0, 9) == 0);
            bus.upd_ready_i = ($urandom_range(0, 2) == 0);
            bus.rob_head_i  = ROB_W'($urandom_range(0, 3));
            for (int c = 0; c < NR_CH; c++) begin
                r = $urandom_range(0, ROB_N - 1);
                for (int t = 0; t < ROB_N; t++) begin
                    ok = !(m_pend && r == m_prob);
                    for (int k = 0; k < c; k++) if (robs[k] == r) ok = 1'b0;
                    if (ok) break;
                    r = (r + 1) % ROB_N;
                end
                robs[c] = r;
                r_op  = 2'($urandom_range(0, 2));
                case ($urandom_range(0, 3))
                    0:       r_pcf = CF_NONE;
                    1:       r_pcf = CF_BRANCH;
                    2:       r_pcf = CF_JALR;
                    default: r_pcf = CF_RET;
                endcase
                r_pc  = $urandom & 32'hFFFF_FFFE;
                r_opa = $urandom;
                r_imm = $urandom;
                r_tgt = (r_op == OP_JALR) ? ((r_opa + r_imm) & 32'hFFFF_FFFE) : (r_pc + r_imm);
                r_pa  = $urandom_range(0, 1) ? r_tgt : $urandom;
                set_ch(c, ($urandom_range(0, 3) != 0), r_op, r_pc, r_opa, r_imm,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_pcf, r_pa, robs[c]);
            end
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
